// File: rtl/prbs_pkg.sv
// Shared PRBS-4 definitions (x^4+x^3+1, period 15) for the generator and checker.
// Latency: none; constants and a pure combinational next-state function.
// Backpressure: not applicable.
package prbs_pkg;

  localparam int PRBS_W = 4;
  localparam logic [PRBS_W-1:0] PRBS_SEED = 4'hf;

  // Feedback taps: b[n+4] = b[n] ^ b[n+1], oldest bit held in state[0].
  localparam int PRBS_TAP_A = 0;
  localparam int PRBS_TAP_B = 1;

  // Checker FSM encodings.
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // One LFSR step: the newly generated bit enters at the MSB.
  function automatic logic [PRBS_W-1:0] prbs4_next(input logic [PRBS_W-1:0] s);
    return {s[PRBS_TAP_A] ^ s[PRBS_TAP_B], s[PRBS_W-1:1]};
  endfunction

endpackage

// File: rtl/prbs_checker_err_window.sv
// Error-rate window for the locked checker: counts valid bits and errors per window.
// Latency: unlock is combinational on the offending bit; counters update on the next edge.
// Backpressure: none; bit_valid qualifies every update, counters hold otherwise.
module prbs_err_window #(
  parameter int WINDOW      = 16,
  parameter int UNLOCK_ERRS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic bit_valid,
  input  logic bit_err,
  output logic unlock
);

  localparam int BW = (WINDOW < 2) ? 1 : $clog2(WINDOW + 1);
  localparam int EW = (UNLOCK_ERRS < 2) ? 1 : $clog2(UNLOCK_ERRS + 1);
  localparam logic [BW-1:0] WIN_LIMIT = BW'(WINDOW);
  localparam logic [EW-1:0] ERR_LIMIT = EW'(UNLOCK_ERRS);

  logic [BW-1:0] win_bits;
  logic [EW-1:0] win_errs;
  logic [BW-1:0] bits_next;
  logic [EW-1:0] errs_next;

  // The error count never exceeds UNLOCK_ERRS-1 between bits, so the +1 cannot overflow.
  assign bits_next = win_bits + BW'(1);
  assign errs_next = win_errs + EW'(bit_err);
  assign unlock    = bit_valid && bit_err && (errs_next == ERR_LIMIT);

  // Window counters: restart on lock entry, on unlock, or when the window fills.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      win_bits <= '0;
      win_errs <= '0;
    end else if (bit_valid) begin
      if (unlock || (bits_next == WIN_LIMIT)) begin
        win_bits <= '0;
        win_errs <= '0;
      end else begin
        win_bits <= bits_next;
        win_errs <= errs_next;
      end
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-4 receiver: search, verify, lock, and count bit errors.
// Latency: locked and err_pulse are registered, one cycle after the deciding valid bit.
// Backpressure: none; data_valid=0 freezes all state and forces err_pulse low.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT  = 8,
  parameter int WINDOW      = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] MATCH_LIMIT = MW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        state;
  logic [1:0]        fill;
  logic [PRBS_W-1:0] lfsr;
  logic [MW-1:0]     match_cnt;

  logic [PRBS_W-1:0] lfsr_adv;
  logic [PRBS_W-1:0] lfsr_fill;
  logic              predicted;
  logic              mismatch;
  logic [MW-1:0]     match_next;
  logic              lock_hit;
  logic              win_bit_valid;
  logic              win_clear;
  logic              unlock;

  // The expected bit is the one the LFSR is about to generate; after a match the
  // advanced state equals the received history, so no reload is ever needed.
  assign lfsr_adv      = prbs4_next(lfsr);
  assign predicted     = lfsr_adv[PRBS_W-1];
  assign mismatch      = data_in != predicted;
  assign lfsr_fill     = {data_in, lfsr[PRBS_W-1:1]};
  assign match_next    = match_cnt + MW'(1);
  assign lock_hit      = match_next == MATCH_LIMIT;
  assign win_bit_valid = data_valid && (state == ST_LOCKED);
  assign win_clear     = data_valid && (state == ST_VERIFY) && !mismatch && lock_hit;
  assign locked        = state == ST_LOCKED;

  prbs_err_window #(
    .WINDOW      (WINDOW),
    .UNLOCK_ERRS (UNLOCK_ERRS)
  ) u_err_window (
    .clk       (clk),
    .reset     (reset),
    .clear     (win_clear),
    .bit_valid (win_bit_valid),
    .bit_err   (mismatch),
    .unlock    (unlock)
  );

  // Synchronisation FSM: fill the LFSR from data, verify predictions, then free-run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_SEARCH;
      fill      <= 2'd0;
      lfsr      <= '0;
      match_cnt <= '0;
    end else if (data_valid) begin
      case (state)
        ST_SEARCH: begin
          lfsr <= lfsr_fill;
          if (fill == 2'd3) begin
            fill <= 2'd0;
            // An all-zero LFSR is the lock-up state and cannot predict anything.
            if (lfsr_fill != '0) begin
              state     <= ST_VERIFY;
              match_cnt <= '0;
            end
          end else begin
            fill <= fill + 2'd1;
          end
        end
        ST_VERIFY: begin
          lfsr <= lfsr_adv;
          if (mismatch) begin
            state <= ST_SEARCH;
            fill  <= 2'd0;
          end else begin
            match_cnt <= match_next;
            if (lock_hit) state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          lfsr <= lfsr_adv;
          if (unlock) begin
            state <= ST_SEARCH;
            fill  <= 2'd0;
          end
        end
        default: begin
          state <= ST_SEARCH;
          fill  <= 2'd0;
        end
      endcase
    end
  end

  // Error pulse and saturating statistics; clear_cnt beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err_pulse <= win_bit_valid && mismatch;
      if (clear_cnt) begin
        err_count <= '0;
        bit_count <= '0;
      end else if (win_bit_valid) begin
        if (bit_count != CNT_MAX) bit_count <= bit_count + CNT_W'(1);
        if (mismatch && (err_count != CNT_MAX)) err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule
